// File: rtl/sysid_checker_master_if.sv
// sysid_checker_master_if
// Groups the check request/result signals and the Avalon-MM read master
// bus of sysid_checker_master.
//   start               request a check (one-cycle pulse)
//   avm_address         word address: 0 = ID word, 1 = timestamp word
//   avm_read            read request
//   avm_waitrequest     slave stall
//   avm_readdata        read data, qualified by avm_readdatavalid
//   avm_readdatavalid   read data qualifier
//   busy, done, pass    sequence status / one-cycle completion / verdict
//   id_mismatch, ts_mismatch, timeout_err   sticky result flags
//   id_value, ts_value  captured read data
// The master modport is the checker side; the slave modport is the side
// that drives start and plays the Avalon slave.
interface sysid_checker_master_if;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        busy;
   logic        done;
   logic        pass;
   logic        id_mismatch;
   logic        ts_mismatch;
   logic        timeout_err;
   logic [31:0] id_value;
   logic [31:0] ts_value;

   modport master (
      input  start, avm_waitrequest, avm_readdata, avm_readdatavalid,
      output avm_address, avm_read, busy, done, pass,
             id_mismatch, ts_mismatch, timeout_err, id_value, ts_value
   );

   modport slave (
      output start, avm_waitrequest, avm_readdata, avm_readdatavalid,
      input  avm_address, avm_read, busy, done, pass,
             id_mismatch, ts_mismatch, timeout_err, id_value, ts_value
   );
endinterface

// File: rtl/sysid_checker_master.sv
// sysid_checker_master
// Reads the system-ID word (address 0) and the timestamp word (address 1)
// from an Avalon-MM slave and compares them with the expected values.
// Ports:
//   clock_i  single clock, all outputs registered on its rising edge
//   reset_i  asynchronous active-high reset
//   bus      sysid_checker_master_if.master (start, Avalon read master,
//            status, result flags and captured values)
module sysid_checker_master #(
   parameter logic [31:0] EXPECTED_ID    = 32'hAA55AA55,
   parameter logic [31:0] EXPECTED_TS    = 32'h5D1BD34E,
   parameter bit          CHECK_TS       = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic                    clock_i,
   input logic                    reset_i,
   sysid_checker_master_if.master bus
);

   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        read_q, read_d;
   logic        addr_q, addr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        id_mm_q, id_mm_d;
   logic        ts_mm_q, ts_mm_d;
   logic        to_q, to_d;
   logic [31:0] id_val_q, id_val_d;
   logic [31:0] ts_val_q, ts_val_d;

   logic in_req, in_wait, is_ts, accept, capture, limit_hit;

   assign in_req    = (state_q == S_ID_REQ)  || (state_q == S_TS_REQ);
   assign in_wait   = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
   assign is_ts     = (state_q == S_TS_REQ)  || (state_q == S_TS_WAIT);
   assign accept    = in_req && read_q && !bus.avm_waitrequest;
   // Read data only counts in a WAIT state or in the acceptance cycle
   // itself (zero-latency slave); anything else is stray and ignored.
   assign capture   = bus.avm_readdatavalid && (in_wait || accept);
   assign limit_hit = (in_req || in_wait) && ((cnt_q + 16'd1) == TO_LIM);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         read_q   <= 1'b0;
         addr_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         id_mm_q  <= 1'b0;
         ts_mm_q  <= 1'b0;
         to_q     <= 1'b0;
         id_val_q <= '0;
         ts_val_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         read_q   <= read_d;
         addr_q   <= addr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         id_mm_q  <= id_mm_d;
         ts_mm_q  <= ts_mm_d;
         to_q     <= to_d;
         id_val_q <= id_val_d;
         ts_val_q <= ts_val_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      read_d   = read_q;
      addr_d   = addr_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      id_mm_d  = id_mm_q;
      ts_mm_d  = ts_mm_q;
      to_d     = to_q;
      id_val_d = id_val_q;
      ts_val_d = ts_val_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_ID_REQ;
               cnt_d    = '0;
               read_d   = 1'b1;
               addr_d   = 1'b0;
               busy_d   = 1'b1;
               pass_d   = 1'b0;
               id_mm_d  = 1'b0;
               ts_mm_d  = 1'b0;
               to_d     = 1'b0;
               id_val_d = '0;
               ts_val_d = '0;
            end
         end
         S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (accept) begin
               read_d = 1'b0;
            end
            // Data wins over a coinciding timeout.
            if (capture) begin
               if (is_ts) begin
                  ts_val_d = bus.avm_readdata;
                  ts_mm_d  = CHECK_TS && (bus.avm_readdata != EXPECTED_TS);
                  state_d  = S_DONE;
               end else begin
                  id_val_d = bus.avm_readdata;
                  id_mm_d  = (bus.avm_readdata != EXPECTED_ID);
                  state_d  = S_TS_REQ;
                  cnt_d    = '0;
                  read_d   = 1'b1;
                  addr_d   = 1'b1;
               end
            end else if (limit_hit) begin
               to_d    = 1'b1;
               state_d = S_DONE;
            end else if (accept) begin
               state_d = is_ts ? S_TS_WAIT : S_ID_WAIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Entry into DONE: registered outputs show the verdict during DONE.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         done_d = 1'b1;
         busy_d = 1'b0;
         read_d = 1'b0;
         pass_d = !(id_mm_d || ts_mm_d || to_d);
      end
   end

   assign bus.avm_address = addr_q;
   assign bus.avm_read    = read_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.pass        = pass_q;
   assign bus.id_mismatch = id_mm_q;
   assign bus.ts_mismatch = ts_mm_q;
   assign bus.timeout_err = to_q;
   assign bus.id_value    = id_val_q;
   assign bus.ts_value    = ts_val_q;

endmodule

// File: tb/tb_sysid_checker_master.sv
module tb_sysid_checker_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sysid_checker_master_if ifc ();
   sysid_checker_master_if ifc2 ();

   sysid_checker_master #(
      .EXPECTED_ID(32'hAA55AA55), .EXPECTED_TS(32'h5D1BD34E),
      .CHECK_TS(1'b1), .TIMEOUT_CYCLES(8)
   ) dut (
      .clock_i(clk), .reset_i(rst), .bus(ifc)
   );

   sysid_checker_master #(
      .EXPECTED_ID(32'hAA55AA55), .EXPECTED_TS(32'h5D1BD34E),
      .CHECK_TS(1'b0), .TIMEOUT_CYCLES(8)
   ) dut2 (
      .clock_i(clk), .reset_i(rst), .bus(ifc2)
   );

   // Configurable Avalon slave for dut
   int          wait_n    = 0;
   int          lat       = 0;
   bit          stall_ts  = 1'b0;
   logic [31:0] mem [2];
   int          stall_cnt = 0;
   int          pend      = 0;
   logic        pend_addr = 1'b0;
   int          acc_cnt   = 0;
   logic        acc_addr [64];
   logic        acc;

   always_comb begin
      ifc.avm_waitrequest   = ifc.avm_read &&
                              ((stall_ts && ifc.avm_address) || (stall_cnt < wait_n));
      acc                   = ifc.avm_read && !ifc.avm_waitrequest;
      ifc.avm_readdatavalid = (acc && lat == 0) || (pend == 1);
      ifc.avm_readdata      = (acc && lat == 0) ? mem[ifc.avm_address] : mem[pend_addr];
   end

   always @(posedge clk) begin
      if (ifc.avm_read && ifc.avm_waitrequest) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;
      if (acc) begin
         acc_addr[acc_cnt % 64] <= ifc.avm_address;
         acc_cnt <= acc_cnt + 1;
      end
      if (acc && lat > 0) begin
         pend      <= lat;
         pend_addr <= ifc.avm_address;
      end else if (pend > 0) begin
         pend <= pend - 1;
      end
   end

   // Zero-latency slave for dut2 with a wrong timestamp
   always_comb begin
      ifc2.avm_waitrequest   = 1'b0;
      ifc2.avm_readdatavalid = ifc2.avm_read;
      ifc2.avm_readdata      = ifc2.avm_address ? 32'h0BADBEEF : 32'hAA55AA55;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_pulse();
      @(negedge clk);
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int cyc);
      cyc = 0;
      while (!ifc.done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_done"}, ifc.done, 1);
   endtask

   initial begin
      int cyc, base, bad, n, n_done, n_rd;
      logic prev_read, saw_rdv, pass_at, tsm_at;
      logic [31:0] ts_at;

      ifc.start  = 1'b0;
      ifc2.start = 1'b0;
      mem[0] = 32'hAA55AA55;
      mem[1] = 32'h5D1BD34E;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", ifc.busy, 0);
      check("rst_read", ifc.avm_read, 0);
      check("rst_addr", ifc.avm_address, 0);
      check("rst_done_pass", {ifc.done, ifc.pass}, 0);
      check("rst_flags", {ifc.id_mismatch, ifc.ts_mismatch, ifc.timeout_err}, 0);
      check("rst_vals", ifc.id_value | ifc.ts_value, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("no_auto_start", {ifc.busy, ifc.avm_read}, 0);
      check("no_auto_acc", acc_cnt, 0);

      // Zero-wait slave
      base = acc_cnt;
      start_pulse();
      check("zw_busy", ifc.busy, 1);
      wait_done("zw", cyc);
      check("zw_fast", (cyc + 1) <= 6, 1);
      check("zw_pass", ifc.pass, 1);
      check("zw_flags", {ifc.id_mismatch, ifc.ts_mismatch, ifc.timeout_err}, 0);
      check("zw_busy_done", ifc.busy, 0);
      check("zw_nacc", acc_cnt - base, 2);
      check("zw_a0", acc_addr[base % 64], 0);
      check("zw_a1", acc_addr[(base + 1) % 64], 1);
      @(negedge clk);
      check("zw_done_1cyc", ifc.done, 0);
      check("zw_pass_hold", ifc.pass, 1);

      // Stalled slave: 3 waitrequest cycles, latency 2
      wait_n = 3;
      lat    = 2;
      start_pulse();
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (!(ifc.avm_read === 1'b1 && ifc.avm_address === 1'b0)) bad++;
         @(negedge clk);
      end
      check("st_hold", bad, 0);
      wait_done("st", cyc);
      check("st_pass", ifc.pass, 1);
      check("st_id", ifc.id_value, 32'hAA55AA55);
      check("st_ts", ifc.ts_value, 32'h5D1BD34E);

      // Wrong ID
      wait_n = 0;
      lat    = 1;
      mem[0] = 32'h12345678;
      base   = acc_cnt;
      start_pulse();
      wait_done("idm", cyc);
      check("idm_flag", ifc.id_mismatch, 1);
      check("idm_tsflag", ifc.ts_mismatch, 0);
      check("idm_pass", ifc.pass, 0);
      check("idm_val", ifc.id_value, 32'h12345678);
      check("idm_ts_read", acc_cnt - base, 2);
      check("idm_ts_val", ifc.ts_value, 32'h5D1BD34E);
      mem[0] = 32'hAA55AA55;

      // Reset while idle with flags set
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rsti_flag", ifc.id_mismatch, 0);
      check("rsti_vals", ifc.id_value | ifc.ts_value, 0);
      @(negedge clk);
      rst = 1'b0;

      // Timestamp never accepted, limit 8
      stall_ts = 1'b1;
      start_pulse();
      n = 0;
      while (!(ifc.avm_read && ifc.avm_address) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("to_tsreq", ifc.avm_read & ifc.avm_address, 1);
      n = 0;
      prev_read = 1'b0;
      while (!ifc.done && n < 50) begin
         prev_read = ifc.avm_read;
         @(negedge clk);
         n++;
      end
      check("to_done", ifc.done, 1);
      check("to_cycles", n, 8);
      check("to_read_before", prev_read, 1);
      check("to_read_drop", ifc.avm_read, 0);
      check("to_flag", ifc.timeout_err, 1);
      check("to_pass", ifc.pass, 0);
      stall_ts = 1'b0;
      repeat (2) @(negedge clk);

      // Reset during ID_WAIT with a late readdatavalid
      lat = 4;
      start_pulse();
      @(negedge clk);
      check("rw_busy", ifc.busy, 1);
      #2 rst = 1'b1;
      #1;
      check("rw_out", {ifc.busy, ifc.avm_read, ifc.avm_address, ifc.done}, 0);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      saw_rdv = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         saw_rdv = saw_rdv | ifc.avm_readdatavalid;
         if (ifc.busy || ifc.done || ifc.id_mismatch || ifc.id_value != 0) bad++;
      end
      check("rw_late_rdv", saw_rdv, 1);
      check("rw_ignored", bad, 0);
      lat = 1;
      start_pulse();
      wait_done("rw_clean", cyc);
      check("rw_clean_pass", ifc.pass, 1);
      check("rw_clean_id", ifc.id_value, 32'hAA55AA55);

      // dut2: CHECK_TS=0, start held across busy and DONE
      @(negedge clk);
      ifc2.start = 1'b1;
      n_done  = 0;
      n_rd    = 0;
      pass_at = 1'b0;
      tsm_at  = 1'b1;
      ts_at   = '0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (i == 3) ifc2.start = 1'b0;
         if (ifc2.done) begin
            n_done++;
            pass_at = ifc2.pass;
            tsm_at  = ifc2.ts_mismatch;
            ts_at   = ifc2.ts_value;
         end
         if (ifc2.avm_read) n_rd++;
      end
      check("nts_ndone", n_done, 1);
      check("nts_nreads", n_rd, 2);
      check("nts_pass", pass_at, 1);
      check("nts_tsm", tsm_at, 0);
      check("nts_ts", ts_at, 32'h0BADBEEF);
      check("nts_idle", ifc2.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sysid_checker_master.md
SYSID_CHECKER_MASTER -- requirements
Module: sysid_checker_master

Interface
REQ-001 The block SHALL have a parameter EXPECTED_ID, default 32'hAA55AA55: the ID word expected at slave word address 0.
REQ-002 The block SHALL have a parameter EXPECTED_TS, default 32'h5D1BD34E: the timestamp word expected at slave word address 1.
REQ-003 The block SHALL have a parameter CHECK_TS, default 1: 1 = compare the timestamp; 0 = read and report it without comparing.
REQ-004 The block SHALL have a parameter TIMEOUT_CYCLES, default 255 (range 1..65535): per-transaction cycle limit.
REQ-005 clock  input  1  single clock for all logic; all outputs are registered on its rising edge.
REQ-006 reset  input  1  asynchronous reset, active-high.
REQ-007 start  input  1  one-cycle request to begin a check; sampled only in IDLE.
REQ-008 avm_address  output  1  Avalon-MM word address (0 = ID, 1 = timestamp).
REQ-009 avm_read  output  1  Avalon-MM read request.
REQ-010 avm_waitrequest  input  1  slave stall; the request is accepted on a cycle where avm_read=1 and avm_waitrequest=0.
REQ-011 avm_readdata  input  32  read data, valid when avm_readdatavalid=1.
REQ-012 avm_readdatavalid  input  1  read-data qualifier.
REQ-013 busy  output  1  high from the cycle after start is accepted until DONE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 pass  output  1  check passed; valid when done=1 and held until the next accepted start.
REQ-016 id_mismatch, ts_mismatch, timeout_err  output  1 each  sticky result flags.
REQ-017 id_value, ts_value  output  32 each  captured read data.

Function
REQ-018 The FSM SHALL have the states IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT and DONE.
REQ-019 IDLE with start=1 SHALL go to ID_REQ, clear all result flags and both value registers, and set busy=1 on the next cycle.
REQ-020 In ID_REQ the block SHALL drive avm_read=1 and avm_address=0 and SHALL hold them stable until acceptance (waitrequest=0).
REQ-021 On acceptance the block SHALL deassert avm_read on the next cycle and enter ID_WAIT, or go directly to the data step if avm_readdatavalid=1 in the acceptance cycle (zero-latency slave).
REQ-022 When avm_readdatavalid=1 during ID_WAIT, the block SHALL capture id_value and set id_mismatch = (avm_readdata != EXPECTED_ID).
REQ-023 After ID capture the block SHALL go to TS_REQ, which repeats the ID_REQ/ID_WAIT handshake with avm_address=1 and captures into ts_value.
REQ-024 ts_mismatch SHALL be set only when CHECK_TS=1 and the captured data != EXPECTED_TS.
REQ-025 After TS capture the block SHALL go to DONE: done=1 for exactly one cycle, busy=0, pass = !(id_mismatch | ts_mismatch | timeout_err), then return to IDLE.
REQ-026 An ID mismatch SHALL NOT abort the sequence; the timestamp read is still performed.
REQ-027 Timeout: a 16-bit counter SHALL clear when entering each REQ state and increment every cycle in REQ/WAIT; when it reaches TIMEOUT_CYCLES without capture, the block SHALL set timeout_err, drop avm_read the same cycle, and go to DONE (pass=0).
REQ-028 If readdatavalid and the timeout limit coincide in the same cycle, the data SHALL win: capture it and set no timeout.
REQ-029 avm_readdatavalid SHALL be ignored outside the WAIT states and outside the acceptance cycle of the REQ states.
REQ-030 start SHALL be ignored while busy=1 or in DONE; there is no queueing.
REQ-031 The block SHALL never have more than one read outstanding.

Reset
REQ-032 On assertion of reset (asynchronous, any state, including mid-transaction), the block SHALL go to IDLE with avm_read=0, avm_address=0, busy=0, done=0, pass=0, all flags 0, id_value=0 and ts_value=0.
REQ-033 Reset deassertion SHALL NOT start a check; a start pulse is required.

Verification
REQ-034 Zero-wait slave returns AA55AA55 then 5D1BD34E, start pulsed -> two reads (address 0, then 1), done pulse with pass=1 and no flags set, and the check completes in 6 cycles or fewer.
REQ-035 Slave holds waitrequest for 3 cycles and data latency is 2 -> avm_read and avm_address held stable through the stall, pass=1, captured values correct.
REQ-036 ID read returns 12345678 -> id_mismatch=1, timestamp still read, pass=0, id_value=12345678.
REQ-037 Timestamp read never returns data, TIMEOUT_CYCLES=8 -> timeout_err=1 on the 8th cycle, avm_read=0, done pulse, pass=0.
REQ-038 Reset asserted during ID_WAIT, then a late readdatavalid arrives -> all outputs 0, readdatavalid ignored, and a following start runs a clean check.
REQ-039 Start re-pulsed while busy, and CHECK_TS=0 with a wrong timestamp -> the second start is ignored and pass=1.
